serial_uart_tx: RTL and testbench



---
 rtl/serial_uart_tx.sv | 239 +++++++++++++++++++++++
 tb/tb_serial_uart_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_uart_tx.sv
// serial_uart_tx: byte FIFO feeding an 8N1 UART transmitter.
// Bytes written on wr_en are queued and sent LSB first on a registered tx line;
// ready_out stalls the writer only while the FIFO is full.
// Optional build macro SERIAL_UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (11-bit frames instead of 10).
module serial_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_en,
  output logic                          ready_out,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef SERIAL_UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  // Transmitter state
  state_t        r_state;
  state_t        w_state_next;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_next;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_next;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_next;
  logic          r_tx;
  logic          w_tx_next;
`ifdef SERIAL_UART_TX_PARITY_EN
  logic          r_parity;
  logic          w_parity_next;
`endif

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_baud_end;
  logic [7:0]    w_head;

  // Full is judged on the registered count, before any same-edge pop, so a
  // write into a full FIFO is always dropped.
  assign w_full     = (r_count == DEPTH_C);
  assign w_push     = wr_en && !w_full;
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_head     = r_mem[r_rd_ptr];

  assign ready_out  = !w_full;
  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

  // Next-state, datapath and next-tx decode for the frame sequencer.
  // NOTE: every signal gets a default before the case so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_baud_next   = r_baud;
    w_bit_next    = r_bit;
    w_pop         = 1'b0;
`ifdef SERIAL_UART_TX_PARITY_EN
    w_parity_next = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
        end
      end

      S_START: begin
        if (w_baud_end) begin
          w_baud_next  = '0;
          w_state_next = S_DATA;
        end else begin
          w_baud_next  = r_baud + 1'b1;
        end
      end

      S_DATA: begin
        if (w_baud_end) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
`ifdef SERIAL_UART_TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_shift_next = {1'b0, r_shift[7:1]};
            w_bit_next   = r_bit + 3'd1;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end

`ifdef SERIAL_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) begin
          w_baud_next  = '0;
          w_state_next = S_STOP;
        end else begin
          w_baud_next  = r_baud + 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (w_baud_end) begin
          w_baud_next  = '0;
          // Chain straight into the next start bit when more data is queued.
          if (r_count != '0) begin
            w_pop = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_baud_next  = '0;
      end
    endcase

    // A pop loads the FIFO head and restarts the frame from the start bit.
    if (w_pop) begin
      w_shift_next  = w_head;
      w_baud_next   = '0;
      w_bit_next    = '0;
      w_state_next  = S_START;
`ifdef SERIAL_UART_TX_PARITY_EN
      w_parity_next = ^w_head;
`endif
    end

    // tx is decoded from the next state so the registered line changes on
    // the same edge the state does.
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
`ifdef SERIAL_UART_TX_PARITY_EN
      S_PARITY: w_tx_next = w_parity_next;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  // Sequencer state register; reset aborts any frame and idles the line high.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_tx     <= 1'b1;
`ifdef SERIAL_UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_shift  <= w_shift_next;
      r_baud   <= w_baud_next;
      r_bit    <= w_bit_next;
      r_tx     <= w_tx_next;
`ifdef SERIAL_UART_TX_PARITY_EN
      r_parity <= w_parity_next;
`endif
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FIFO data storage.
  // NOTE: the array is deliberately not reset; the pointers and count define
  // which entries are valid, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_serial_uart_tx.sv
// tb_serial_uart_tx: directed self-checking bench for serial_uart_tx with
// CLKS_PER_BIT=4 and FIFO_DEPTH=4. Frame shape follows SERIAL_UART_TX_PARITY_EN.
module tb_serial_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef SERIAL_UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       clock;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       ready_out;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  serial_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .ready_out (ready_out),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and return at the following falling edge for sampling.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check tx against the expected frame for byte b, sample k0..FRAME-1,
  // where sample 0 is the falling edge right after the pop edge.
  task automatic expect_frame(input logic [7:0] b, input int k0);
    logic exp;
    for (int k = k0; k < FRAME; k++) begin
      if (k < CPB)
        exp = 1'b0;
      else if (k < 9 * CPB)
        exp = b[3'((k - CPB) / CPB)];
`ifdef SERIAL_UART_TX_PARITY_EN
      else if (k < 10 * CPB)
        exp = ^b;
`endif
      else
        exp = 1'b1;
      check($sformatf("tx_%02h_k%0d", b, k), {31'd0, tx}, {31'd0, exp});
      step();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"},        {31'd0, tx},        32'd1);
    check({tag, "_ready"},     {31'd0, ready_out}, 32'd1);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_count"},     {29'd0, fifo_count}, 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;

    // Reset held 10 cycles, then released.
    repeat (10) step();
    check_idle("rst_hold");
    reset = 1'b0;
    step();
    check_idle("rst_rel");
    check("rst_ovf", {31'd0, overflow}, 32'd0);

    // Single byte 0x48 into an idle block.
    wr_en = 1'b1; wr_data = 8'h48;
    step();
    wr_en = 1'b0;
    check("h_count_push", {29'd0, fifo_count}, 32'd1);
    check("h_busy_push",  {31'd0, busy},       32'd1);
    check("h_tx_idle",    {31'd0, tx},         32'd1);
    step();
    check("h_count_pop",  {29'd0, fifo_count}, 32'd0);
    expect_frame(8'h48, 0);
    check("h_busy_done",  {31'd0, busy},       32'd0);
    check("h_tx_done",    {31'd0, tx},         32'd1);

    // Six writes 0x41..0x46 back to back; the sixth hits a full FIFO.
    wr_en = 1'b1; wr_data = 8'h41;
    step();
    check("burst_cnt0", {29'd0, fifo_count}, 32'd1);
    wr_data = 8'h42;
    step();
    check("burst_cnt1", {29'd0, fifo_count}, 32'd1);
    check("burst_tx1",  {31'd0, tx},         32'd0);
    wr_data = 8'h43;
    step();
    check("burst_cnt2", {29'd0, fifo_count}, 32'd2);
    wr_data = 8'h44;
    step();
    check("burst_cnt3", {29'd0, fifo_count}, 32'd3);
    wr_data = 8'h45;
    step();
    check("burst_cnt4",  {29'd0, fifo_count}, 32'd4);
    check("burst_ready", {31'd0, ready_out},  32'd0);
    check("burst_ovf0",  {31'd0, overflow},   32'd0);
    wr_data = 8'h46;
    step();
    wr_en = 1'b0;
    check("burst_ovf1",  {31'd0, overflow},   32'd1);
    check("burst_cnt5",  {29'd0, fifo_count}, 32'd4);
    expect_frame(8'h41, 4);
    expect_frame(8'h42, 0);
    expect_frame(8'h43, 0);
    expect_frame(8'h44, 0);
    expect_frame(8'h45, 0);
    check("burst_busy",  {31'd0, busy},       32'd0);
    check("burst_empty", {29'd0, fifo_count}, 32'd0);
    check("burst_ovf2",  {31'd0, overflow},   32'd1);
    check("burst_tx",    {31'd0, tx},         32'd1);

    // Full FIFO with a pop and a write on the same edge.
    reset = 1'b1;
    step();
    check("rst2_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    step();
    wr_en = 1'b1; wr_data = 8'h10;
    step();
    wr_data = 8'h11;
    step();
    wr_data = 8'h12;
    step();
    wr_data = 8'h13;
    step();
    wr_data = 8'h14;
    step();
    wr_en = 1'b0;
    check("same_cnt_full", {29'd0, fifo_count}, 32'd4);
    repeat (FRAME - 4) step();
    check("same_cnt_pre",  {29'd0, fifo_count}, 32'd4);
    check("same_ready",    {31'd0, ready_out},  32'd0);
    check("same_ovf0",     {31'd0, overflow},   32'd0);
    wr_en = 1'b1; wr_data = 8'h99;
    step();
    wr_en = 1'b0;
    check("same_cnt_post", {29'd0, fifo_count}, 32'd3);
    check("same_ovf1",     {31'd0, overflow},   32'd1);
    expect_frame(8'h11, 0);
    expect_frame(8'h12, 0);
    expect_frame(8'h13, 0);
    expect_frame(8'h14, 0);
    check("same_busy",     {31'd0, busy},       32'd0);
    check("same_tx",       {31'd0, tx},         32'd1);

    // Reset mid-DATA of 0x55 with two bytes queued.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    wr_en = 1'b1; wr_data = 8'h55;
    step();
    wr_data = 8'hAA;
    step();
    wr_data = 8'h0F;
    step();
    wr_en = 1'b0;
    repeat (9) step();
    check("mid_cnt",  {29'd0, fifo_count}, 32'd2);
    check("mid_tx",   {31'd0, tx},         32'd0);
    reset = 1'b1;
    step();
    check_idle("mid_rst");
    check("mid_ovf",  {31'd0, overflow},   32'd0);
    reset = 1'b0;
    for (int i = 0; i < FRAME + 4; i++) begin
      step();
      check($sformatf("mid_quiet_%0d", i), {31'd0, tx}, 32'd1);
    end
    check("mid_busy", {31'd0, busy}, 32'd0);

    // Parity-sensitive bytes (even parity 1 for 0x07, 0 for 0x03 when enabled).
    wr_en = 1'b1; wr_data = 8'h07;
    step();
    wr_en = 1'b0;
    step();
    expect_frame(8'h07, 0);
    check("p07_busy", {31'd0, busy}, 32'd0);
    wr_en = 1'b1; wr_data = 8'h03;
    step();
    wr_en = 1'b0;
    step();
    expect_frame(8'h03, 0);
    check("p03_busy", {31'd0, busy}, 32'd0);
    check("p03_tx",   {31'd0, tx},   32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
